serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised multi-cycle adder: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Adds DIGIT bits per clock, LSB digit first, through a combinational digit adder built from cascaded half-adder/full-adder cells.
- Returns sum, carry-out and signed overflow over a second valid/ready handshake.
- Area-optimised replacement for wide single-cycle adders in the arithmetic datapath; latency/area trade set by DIGIT.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be ≥ 1.
- DIGIT, 1, bits added per cycle; must satisfy 1 ≤ DIGIT ≤ WIDTH and WIDTH % DIGIT == 0 (elaboration-time assertion).
- NDIG (localparam), WIDTH/DIGIT, cycles per addition.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  unsigned carry out of MSB.
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE, digit counter 0, sum 0, cout 0, overflow 0, out_valid 0, in_ready 1.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
  - Both are decoded from registered state only; no combinational input-to-output path.
- IDLE: on an edge with in_valid && in_ready:
  - capture a, b, cin into internal shift registers;
  - clear the counter;
  - go to BUSY.
- BUSY: each edge adds the low DIGIT bits of the operand shift registers plus the running carry.
  - Shift the result digit into the internal sum register from the MSB side.
  - Shift the operands right by DIGIT.
  - Register the digit carry.
  - Increment the counter.
- End of BUSY: on the edge that processes digit NDIG-1:
  - load sum, cout and overflow output registers from the completed result;
  - go to DONE.
- Latency: accept edge k, out_valid high after edge k+NDIG. Holds for NDIG = 1 (DIGIT = WIDTH): BUSY lasts exactly one cycle.
- DONE: hold all outputs stable until out_ready is sampled high, then go to IDLE.
  - in_ready rises the cycle after the output handshake; no accept in the same cycle as the output handshake.
- Output registers change only on BUSY→DONE. They keep the last result in IDLE and BUSY and are meaningful only while out_valid = 1.
- Operand or cin changes after the accept edge are ignored. in_valid in BUSY/DONE is ignored with no queueing.
- Reset mid-operation (BUSY or DONE): immediate return to reset values; the partial result is discarded.
- Overflow: the digit adder exposes both the carry into its top bit and its carry-out. The register value comes from the final digit.
- Counter width: max(1, $clog2(NDIG)); no wrap, since it is cleared on accept.

Decomposition:
- Package adder_pkg: state enum type (IDLE, BUSY, DONE) and the encoding width constant.
- Sub-module digit_adder, parameter W = DIGIT:
  - ports a, b, cin, sum, cout, c_msb (carry into the top bit);
  - purely combinational ripple of full-adder cells, each formed from two half-adder stages plus an OR.
- serial_adder holds the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=8, DIGIT=1: a=8'h5A, b=8'h3C, cin=0, accepted at edge k -> out_valid after edge k+8; sum=8'h96, cout=0, overflow=1.
- WIDTH=8, DIGIT=1, each run below: after each result, check in_ready rises the cycle after the output handshake.
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0.
  - a=8'h80, b=8'h80 -> sum=8'h00, cout=1, overflow=1.
  - a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, cout=0, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, new operands not accepted. Then out_ready=1 -> IDLE, accept next.
- Reset mid-BUSY: assert rst asynchronously after 3 digits -> out_valid=0, sum=0, cout=0, in_ready=1 immediately. Next operation after release computes correctly.
- Parameter sweep WIDTH=8 with DIGIT=2, 4, 8 -> latency 4, 2, 1 cycles.
  - Check 1000 random a, b, cin against the reference model {cout,sum} = a+b+cin.
  - Overflow model: (a[7]==b[7]) && (sum[7]!=a[7]).
- Operand hold: change a, b on the cycle after accept -> result reflects captured values only.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for the digit-serial adder: FSM state encoding.
package adder_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/digit_adder.sv
// Combinational W-bit ripple adder of full-adder cells, each built from two half adders plus an OR.
module digit_adder #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);
  logic [W:0] c;
  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic h1_s, h1_c, h2_s, h2_c;
    assign h1_s   = a[i] ^ b[i];
    assign h1_c   = a[i] & b[i];
    assign h2_s   = h1_s ^ c[i];
    assign h2_c   = h1_s & c[i];
    assign sum[i] = h2_s;
    assign c[i+1] = h1_c | h2_c;
  end

  assign cout  = c[W];
  // Carry into the top bit; XOR with cout yields signed overflow.
  assign c_msb = c[W-1];
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds DIGIT bits per clock, LSB digit first, with valid/ready on both sides.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: DIGIT must divide WIDTH and satisfy 1 <= DIGIT <= WIDTH");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic [DIGIT-1:0] dsum;
  logic             dcout, dcmsb, last;

  digit_adder #(.W(DIGIT)) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (dsum),
    .cout  (dcout),
    .c_msb (dcmsb)
  );

  assign last  = (cnt_q == CW'(NDIG - 1));
  // New digit enters from the MSB side so that after NDIG shifts the LSB digit lands at bit 0.
  assign acc_d = (acc_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          carry_q <= cin;
          cnt_q   <= '0;
        end
        BUSY: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= dcout;
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            sum_q  <= acc_d;
            cout_q <= dcout;
            ovf_q  <= dcout ^ dcmsb;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: four instances with DIGIT = 1, 2, 4, 8 at WIDTH = 8.
module tb_serial_adder;
  localparam int N = 4;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid_s  [N];
  logic       out_ready_s [N];
  logic [7:0] a_s [N];
  logic [7:0] b_s [N];
  logic       cin_s [N];
  wire        in_ready_w  [N];
  wire        out_valid_w [N];
  wire  [7:0] sum_w [N];
  wire        cout_w [N];
  wire        ovf_w  [N];

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    serial_adder #(.WIDTH(8), .DIGIT(1 << g)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_w[g]),
      .a         (a_s[g]),
      .b         (b_s[g]),
      .cin       (cin_s[g]),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready_s[g]),
      .sum       (sum_w[g]),
      .cout      (cout_w[g]),
      .overflow  (ovf_w[g])
    );
  end

  function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic ci);
    exp_t e;
    logic [8:0] t;
    t   = {1'b0, av} + {1'b0, bv} + {8'd0, ci};
    e.s = t[7:0];
    e.c = t[8];
    e.o = (av[7] == bv[7]) && (t[7] != av[7]);
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b1;
      a_s[i] = 8'h00; b_s[i] = 8'h00; cin_s[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (in_ready_w[i] !== 1'b1 || out_valid_w[i] !== 1'b0 || sum_w[i] !== 8'h00 ||
          cout_w[i] !== 1'b0 || ovf_w[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset dut%0d: rdy=%b vld=%b sum=%h cout=%b ovf=%b, required rdy=1 vld=0 sum=00 cout=0 ovf=0",
                 i, in_ready_w[i], out_valid_w[i], sum_w[i], cout_w[i], ovf_w[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One operation with out_ready held high; optionally scrambles the operands after the accept edge.
  task automatic run_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input bit scramble);
    exp_t e;
    int   lat;
    checks++;
    if (in_ready_w[idx] !== 1'b1) begin
      failures++;
      $display("FAIL pre_accept_ready dut%0d: in_ready=%b, required 1", idx, in_ready_w[idx]);
    end
    in_valid_s[idx] = 1'b1; a_s[idx] = av; b_s[idx] = bv; cin_s[idx] = ci;
    sb_q.push_back(model(av, bv, ci));
    @(negedge clk);
    in_valid_s[idx] = 1'b0;
    if (scramble) begin
      a_s[idx] = ~av; b_s[idx] = av ^ bv ^ 8'h5A; cin_s[idx] = ~ci;
    end
    lat = 0;
    while (out_valid_w[idx] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    checks++;
    if (lat != (8 >> idx)) begin
      failures++;
      $display("FAIL latency dut%0d: got %0d cycles, required %0d", idx, lat, 8 >> idx);
    end
    checks++;
    if (sum_w[idx] !== e.s || cout_w[idx] !== e.c || ovf_w[idx] !== e.o || in_ready_w[idx] !== 1'b0) begin
      failures++;
      $display("FAIL result dut%0d a=%h b=%h cin=%b: sum=%h cout=%b ovf=%b rdy=%b, required sum=%h cout=%b ovf=%b rdy=0",
               idx, av, bv, ci, sum_w[idx], cout_w[idx], ovf_w[idx], in_ready_w[idx], e.s, e.c, e.o);
    end
    @(negedge clk);
    checks++;
    if (in_ready_w[idx] !== 1'b1 || out_valid_w[idx] !== 1'b0) begin
      failures++;
      $display("FAIL post_handshake dut%0d: in_ready=%b out_valid=%b, required 1 and 0",
               idx, in_ready_w[idx], out_valid_w[idx]);
    end
  endtask

  task automatic test_directed;
    run_op(0, 8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(0, 8'h80, 8'h80, 1'b0, 1'b0);
    run_op(0, 8'h7F, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure;
    exp_t e;
    int   lat;
    out_ready_s[0] = 1'b0;
    in_valid_s[0] = 1'b1; a_s[0] = 8'h12; b_s[0] = 8'h34; cin_s[0] = 1'b1;
    sb_q.push_back(model(8'h12, 8'h34, 1'b1));
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    lat = 0;
    while (out_valid_w[0] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb_q.pop_front();
    checks++;
    if (out_valid_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL bp_timeout: out_valid=%b, required 1", out_valid_w[0]);
    end
    in_valid_s[0] = 1'b1; a_s[0] = 8'hAA; b_s[0] = 8'h55; cin_s[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_w[0] !== 1'b1 || in_ready_w[0] !== 1'b0 || sum_w[0] !== e.s ||
          cout_w[0] !== e.c || ovf_w[0] !== e.o) begin
        failures++;
        $display("FAIL bp_hold cyc%0d: vld=%b rdy=%b sum=%h cout=%b ovf=%b, required vld=1 rdy=0 sum=%h cout=%b ovf=%b",
                 i, out_valid_w[0], in_ready_w[0], sum_w[0], cout_w[0], ovf_w[0], e.s, e.c, e.o);
      end
    end
    in_valid_s[0] = 1'b0;
    out_ready_s[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready_w[0] !== 1'b1 || out_valid_w[0] !== 1'b0 || sum_w[0] !== e.s) begin
      failures++;
      $display("FAIL bp_release: rdy=%b vld=%b sum=%h, required rdy=1 vld=0 sum=%h",
               in_ready_w[0], out_valid_w[0], sum_w[0], e.s);
    end
    run_op(0, 8'hC3, 8'h3D, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_busy;
    in_valid_s[0] = 1'b1; a_s[0] = 8'h66; b_s[0] = 8'h77; cin_s[0] = 1'b1;
    @(posedge clk);
    #1 in_valid_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid_w[0] !== 1'b0 || in_ready_w[0] !== 1'b1 || sum_w[0] !== 8'h00 ||
        cout_w[0] !== 1'b0 || ovf_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_busy: vld=%b rdy=%b sum=%h cout=%b ovf=%b, required vld=0 rdy=1 sum=00 cout=0 ovf=0",
               out_valid_w[0], in_ready_w[0], sum_w[0], cout_w[0], ovf_w[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(0, 8'h66, 8'h77, 1'b1, 1'b0);
  endtask

  task automatic test_operand_hold;
    for (int i = 0; i < N; i++) run_op(i, 8'h9C, 8'hA7, 1'b1, 1'b1);
  endtask

  task automatic test_sweep;
    for (int i = 1; i < N; i++) begin
      run_op(i, 8'hFF, 8'hFF, 1'b1, 1'b0);
      for (int k = 0; k < 1000; k++)
        run_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_busy();
    test_operand_hold();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
